// File: rtl/scan_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : scan_arbiter
//  Purpose  : Shares one SCAN serial-receive parser among N_REQ command
//             clients. Arbitrates requests, sequences SCAN's req/ack
//             handshake, returns the parsed word and flag to the winner,
//             and reports (without aborting) over-long transactions.
//  Options  : SCAN_ARB_FIXED_PRIO_EN - when defined, fixed priority with
//             the lowest index winning; otherwise round-robin.
//  Revision : 1.0 - initial release
// ============================================================================
module scan_arbiter #(
  parameter int N_REQ  = 2,
  parameter int TO_CYC = 4096,
  parameter int TO_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] type_i,
  output logic [N_REQ-1:0] ack_o,
  output logic [31:0]      din_o,
  output logic             flag_o,
  output logic [N_REQ-1:0] grant_o,
  output logic             timeout_o,
  output logic             req_rx,
  output logic             type_rx,
  input  logic             ack_rx,
  input  logic             flag_rx,
  input  logic [31:0]      din_rx
);

  // Client index width (N_REQ is limited to 2..4)
  localparam int IW = (N_REQ > 2) ? 2 : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  logic [1:0]       state;
  logic             any_req;
  logic [IW-1:0]    win_idx;
  logic [N_REQ-1:0] win_onehot;

  // Arbitration only happens in IDLE, so a client that was just acked is
  // never considered during its DONE and GAP cycles; a late req_i drop
  // therefore cannot win a second transaction.
`ifdef SCAN_ARB_FIXED_PRIO_EN
  // Fixed priority: scan from the top so the lowest requesting index wins
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        any_req = 1'b1;
        win_idx = IW'(k);
      end
    end
  end
`else
  localparam logic [IW:0] N_W = (IW + 1)'(N_REQ);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_idx;
  logic [IW:0]   nxt_ptr;

  // Round-robin: first requester found starting at rr_ptr, wrapping mod N_REQ
  always_comb begin
    logic [IW:0] pos;
    any_req = 1'b0;
    win_idx = '0;
    pos     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = {1'b0, rr_ptr} + (IW + 1)'(k);
      if (pos >= N_W) pos = pos - N_W;
      if (!any_req && req_i[pos[IW-1:0]]) begin
        any_req = 1'b1;
        win_idx = pos[IW-1:0];
      end
    end
  end

  // Pointer successor of the current owner, wrapped to the client count
  always_comb begin
    nxt_ptr = {1'b0, gnt_idx} + (IW + 1)'(1);
    if (nxt_ptr >= N_W) nxt_ptr = '0;
  end

  // Remember the owner and move the pointer past it once it has been acked
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      gnt_idx <= '0;
    end else begin
      if (state == ST_IDLE && any_req) gnt_idx <= win_idx;
      if (state == ST_DONE)            rr_ptr  <= nxt_ptr[IW-1:0];
    end
  end
`endif

  // One-hot form of the winning index
  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  // Transaction sequencer: IDLE -> ISSUE -> DONE -> GAP -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      req_rx  <= 1'b0;
      type_rx <= 1'b0;
      ack_o   <= '0;
      grant_o <= '0;
      din_o   <= '0;
      flag_o  <= 1'b0;
    end else begin
      ack_o <= '0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant_o <= win_onehot;
            type_rx <= type_i[win_idx];
            req_rx  <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Non-cancellable: req_i of the owner is not looked at here
          if (ack_rx) begin
            din_o  <= din_rx;
            flag_o <= flag_rx;
            req_rx <= 1'b0;
            ack_o  <= grant_o;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          grant_o <= '0;
          state   <= ST_GAP;
        end
        ST_GAP: begin
          // Hold off until SCAN's ack is low so a stale ack cannot be reused
          if (!ack_rx) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  generate
    if (TO_CYC > 0) begin : g_timeout
      localparam logic [TO_W-1:0] TO_MAX = TO_W'(TO_CYC);
      logic [TO_W-1:0] to_cnt;

      // Saturating count of ISSUE cycles; cleared when the ack arrives
      always_ff @(posedge clk) begin
        if (rst) begin
          to_cnt <= '0;
        end else if (state == ST_ISSUE) begin
          if (ack_rx)                to_cnt <= '0;
          else if (to_cnt != TO_MAX) to_cnt <= to_cnt + TO_W'(1);
        end else begin
          to_cnt <= '0;
        end
      end

      assign timeout_o = (to_cnt == TO_MAX);
    end else begin : g_no_timeout
      assign timeout_o = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire
